// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the 2:1 instruction/data RAM arbiter.
//   state_e    : arbiter FSM states
//   req_id_e   : requester identity; the value doubles as its bit index in req vectors
//   WORD_W     : RAM / bus word width
//   addr_valid : word-aligned and inside the 2**aw word RAM
package mem_arb_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // True when the byte address is word aligned and all bits above the word index are zero.
  function automatic logic addr_valid(input logic [WORD_W-1:0] addr, input int unsigned aw);
    return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/mem_arbiter_2to1_if.sv
// mem_arbiter_2to1_if: bundles the CPU-side request ports and the RAM-side port
// of the arbiter.
//   slave  modport : arbiter view (takes requests, drives acks and the RAM)
//   master modport : environment view (CPU core plus RAM instance)
interface mem_arbiter_2to1_if;
  import mem_arb_pkg::*;

  logic              i_req;
  logic [WORD_W-1:0] i_addr;
  logic              i_ack;
  logic [WORD_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [WORD_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              d_ack;
  logic [WORD_W-1:0] d_rdata;
  logic [WORD_W-1:0] ram_a;
  logic              ram_we;
  logic [WORD_W-1:0] ram_wd;
  logic [WORD_W-1:0] ram_rd;
  logic              err;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rd,
    output i_ack, i_rdata, d_ack, d_rdata, ram_a, ram_we, ram_wd, err, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rd,
    input  i_ack, i_rdata, d_ack, d_rdata, ram_a, ram_we, ram_wd, err, busy
  );

endinterface

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-way round-robin picker holding the priority bit.
//   clk, rst  : clock, asynchronous active-high reset
//   req[1:0]  : requests, indexed by req_id_e
//   mask[1:0] : eligibility mask applied to req
//   update    : on a completed access, hand priority to the requester left eligible by mask
//   grant     : winning requester (valid when any_grant)
//   any_grant : at least one eligible request
module mem_arb_rr
  import mem_arb_pkg::*;
#(
  parameter int RESET_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       update,
  output req_id_e    grant,
  output logic       any_grant
);

  req_id_e    prio_q, prio_d;
  logic [1:0] eligible_s;

  assign eligible_s = req & mask;
  assign any_grant  = |eligible_s;

  // Pick the winner; the priority holder only matters when both are eligible.
  always_comb begin
    grant = prio_q;
    case (eligible_s)
      2'b11:   grant = prio_q;
      2'b10:   grant = REQ_D;
      2'b01:   grant = REQ_I;
      default: grant = prio_q;
    endcase
  end

  // During a response the mask leaves only the other requester eligible, so it names the new holder.
  always_comb begin
    prio_d = prio_q;
    if (update) begin
      prio_d = mask[REQ_D] ? REQ_D : REQ_I;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= (RESET_PRIO != 0) ? REQ_D : REQ_I;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mem_arbiter_2to1.sv
// mem_arbiter_2to1: shares one single-port word-addressed RAM (1-cycle registered
// read) between the instruction-fetch and load/store ports of the core.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : i_* fetch port, d_* load/store port, ram_* RAM port, err, busy
// Flow: IDLE latches the winner -> ISSUE drives the RAM -> RESP acks with ram_rd.
// RESP may chain straight into ISSUE for the other requester.
module mem_arbiter_2to1
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int RESET_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_arbiter_2to1_if.slave    bus
);

  state_e            state_q, state_d;
  req_id_e           win_q, win_d;
  logic              we_q, we_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] ram_a_q, ram_a_d;
  logic [WORD_W-1:0] ram_wd_q, ram_wd_d;
  logic [WORD_W-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_W-1:0] d_rdata_q, d_rdata_d;

  logic [1:0]        rr_mask_s;
  logic              rr_update_s;
  req_id_e           rr_grant_s;
  logic              rr_any_s;
  logic              latch_s;
  logic [WORD_W-1:0] sel_addr_s;
  logic [WORD_W-1:0] sel_wdata_s;
  logic              sel_we_s;
  logic [WORD_W-1:0] resp_rdata_s;

  mem_arb_rr #(
    .RESET_PRIO (RESET_PRIO)
  ) u_rr (
    .clk       (clk),
    .rst       (reset),
    .req       ({bus.d_req, bus.i_req}),
    .mask      (rr_mask_s),
    .update    (rr_update_s),
    .grant     (rr_grant_s),
    .any_grant (rr_any_s)
  );

  // Request fields of the current winner; fetches never write, so ram_wd keeps its value.
  always_comb begin
    sel_addr_s  = bus.i_addr;
    sel_we_s    = 1'b0;
    sel_wdata_s = ram_wd_q;
    if (rr_grant_s == REQ_D) begin
      sel_addr_s  = bus.d_addr;
      sel_we_s    = bus.d_we;
      sel_wdata_s = bus.d_wdata;
    end else begin
      sel_addr_s  = bus.i_addr;
      sel_we_s    = 1'b0;
      sel_wdata_s = ram_wd_q;
    end
  end

  // Rejected accesses return zero instead of whatever the RAM produced.
  assign resp_rdata_s = valid_q ? bus.ram_rd : 32'd0;

  // Next-state logic and latching of the granted request.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    we_d        = we_q;
    valid_d     = valid_q;
    ram_a_d     = ram_a_q;
    ram_wd_d    = ram_wd_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    rr_mask_s   = 2'b11;
    rr_update_s = 1'b0;
    latch_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_any_s) begin
          latch_s = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        // The requester being acked is masked out so only the other one can chain in.
        rr_mask_s   = (win_q == REQ_I) ? 2'b10 : 2'b01;
        rr_update_s = 1'b1;
        if (win_q == REQ_I) begin
          i_rdata_d = resp_rdata_s;
        end else begin
          d_rdata_d = resp_rdata_s;
        end
        if (rr_any_s) begin
          latch_s = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // ram_a/ram_wd load on entry to ISSUE so they are stable for the whole ISSUE cycle.
    if (latch_s) begin
      win_d    = rr_grant_s;
      we_d     = sel_we_s;
      valid_d  = addr_valid(sel_addr_s, ADDR_W);
      ram_a_d  = {{(WORD_W-ADDR_W){1'b0}}, sel_addr_s[ADDR_W+1:2]};
      ram_wd_d = sel_wdata_s;
    end else begin
      win_d    = win_q;
      we_d     = we_q;
      valid_d  = valid_q;
      ram_a_d  = ram_a_q;
      ram_wd_d = ram_wd_q;
    end
  end

  // State and latched-request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      win_q     <= REQ_I;
      we_q      <= 1'b0;
      valid_q   <= 1'b0;
      ram_a_q   <= 32'd0;
      ram_wd_q  <= 32'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      valid_q   <= valid_d;
      ram_a_q   <= ram_a_d;
      ram_wd_q  <= ram_wd_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Outputs decode registered state only; reset clears state_q at once, dropping ram_we.
  assign bus.i_ack   = (state_q == RESP) && (win_q == REQ_I);
  assign bus.d_ack   = (state_q == RESP) && (win_q == REQ_D);
  assign bus.err     = (state_q == RESP) && !valid_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.ram_we  = (state_q == ISSUE) && we_q && valid_q;
  assign bus.ram_a   = ram_a_q;
  assign bus.ram_wd  = ram_wd_q;
  // Read data comes straight off ram_rd in the ack cycle, then holds from the register.
  assign bus.i_rdata = bus.i_ack ? resp_rdata_s : i_rdata_q;
  assign bus.d_rdata = bus.d_ack ? resp_rdata_s : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// tb_mem_arbiter_2to1: directed bench for mem_arbiter_2to1 with a behavioural
// 4096-word RAM (synchronous write, registered read).
module tb_mem_arbiter_2to1;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  mem_arbiter_2to1_if bus ();

  mem_arbiter_2to1 #(.ADDR_W(12), .RESET_PRIO(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model; preloads go through the same process so only one block writes mem.
  logic [31:0] mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_a;
  logic [31:0] pre_d;

  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (bus.ram_we) mem[bus.ram_a[11:0]] <= bus.ram_wd;
    bus.ram_rd <= mem[bus.ram_a[11:0]];
  end

  // Count RAM write cycles and acks, sampled away from the active edge.
  int          we_cnt;
  int          ack_cnt;
  logic [31:0] we_a;
  logic [31:0] we_wd;
  always @(negedge clk) begin
    if (bus.ram_we) begin
      we_cnt = we_cnt + 1;
      we_a   = bus.ram_a;
      we_wd  = bus.ram_wd;
    end
    if (bus.i_ack || bus.d_ack) ack_cnt = ack_cnt + 1;
  end

  // Request fields must stay stable while a request is pending.
  logic        i_req_p, d_req_p, d_we_p;
  logic [31:0] i_addr_p, d_addr_p, d_wdata_p;
  always @(posedge clk) begin
    if (!reset && i_req_p && bus.i_req && !bus.i_ack)
      assert (bus.i_addr == i_addr_p) else $error("protocol: i_addr changed before i_ack");
    if (!reset && d_req_p && bus.d_req && !bus.d_ack)
      assert (bus.d_addr == d_addr_p && bus.d_we == d_we_p && bus.d_wdata == d_wdata_p)
        else $error("protocol: d-port fields changed before d_ack");
    i_req_p   <= bus.i_req;
    i_addr_p  <= bus.i_addr;
    d_req_p   <= bus.d_req;
    d_we_p    <= bus.d_we;
    d_addr_p  <= bus.d_addr;
    d_wdata_p <= bus.d_wdata;
  end

  task automatic apply_reset();
    reset       = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = 32'd0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'd0;
    bus.d_wdata = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One access on one port; lat = negedges from request to ack, -1 on timeout.
  task automatic access(input bit port_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic e, output int lat);
    @(negedge clk);
    if (port_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    lat = -1; rdata = 32'd0; e = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (port_d ? bus.d_ack : bus.i_ack) begin
        lat = c; rdata = port_d ? bus.d_rdata : bus.i_rdata; e = bus.err;
        break;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  // Both ports request loads in the same cycle; ci/cd are ack cycles (-1 if missing).
  task automatic both_round(output int ci, output int cd,
                            output logic [31:0] ir, output logic [31:0] dr);
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h14;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    ci = -1; cd = -1; ir = 32'd0; dr = 32'd0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.i_ack) begin ci = c; ir = bus.i_rdata; bus.i_req = 1'b0; end
      if (bus.d_ack) begin cd = c; dr = bus.d_rdata; bus.d_req = 1'b0; end
      if (ci > 0 && cd > 0) break;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    reset = 1'b1;
    #1;
    n_vec++;
    if ({bus.i_ack, bus.d_ack, bus.err, bus.busy, bus.ram_we} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000",
                        {bus.i_ack, bus.d_ack, bus.err, bus.busy, bus.ram_we});
    end
    n_vec++;
    if ({bus.ram_a, bus.ram_wd, bus.i_rdata, bus.d_rdata} !== 128'd0) begin
      n_err++; $display("FAIL reset_data: ram_a=%h ram_wd=%h i_rdata=%h d_rdata=%h want all 0",
                        bus.ram_a, bus.ram_wd, bus.i_rdata, bus.d_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_load();
    logic [31:0] rd; logic e; int lat;
    preload(12'd5, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h14, 32'd0, rd, e, lat);
    n_vec++;
    if (lat !== 2) begin n_err++; $display("FAIL load_latency: got %0d want 2", lat); end
    n_vec++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      n_err++; $display("FAIL load_data: got %h err=%b want deadbeef err=0", rd, e);
    end
    @(negedge clk);
    n_vec++;
    if (bus.d_ack !== 1'b0 || bus.d_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL load_hold: d_ack=%b d_rdata=%h want 0 deadbeef", bus.d_ack, bus.d_rdata);
    end
  endtask

  task automatic test_store_fetch();
    logic [31:0] rd; logic e; int lat;
    we_cnt = 0;
    access(1'b1, 1'b1, 32'h10, 32'hCAFEF00D, rd, e, lat);
    n_vec++;
    if (lat !== 2 || e !== 1'b0) begin
      n_err++; $display("FAIL store_ack: lat=%0d err=%b want 2 0", lat, e);
    end
    n_vec++;
    if (we_cnt !== 1 || we_a !== 32'd4 || we_wd !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL store_ram: we_cycles=%0d ram_a=%h ram_wd=%h want 1 4 cafef00d",
                        we_cnt, we_a, we_wd);
    end
    n_vec++;
    if (mem[4] !== 32'hCAFEF00D) begin n_err++; $display("FAIL store_mem: got %h want cafef00d", mem[4]); end
    access(1'b0, 1'b0, 32'h10, 32'd0, rd, e, lat);
    n_vec++;
    if (rd !== 32'hCAFEF00D || lat !== 2 || e !== 1'b0) begin
      n_err++; $display("FAIL fetch: got %h lat=%0d err=%b want cafef00d 2 0", rd, lat, e);
    end
    n_vec++;
    if (we_cnt !== 1) begin n_err++; $display("FAIL fetch_no_write: we_cycles=%0d want 1", we_cnt); end
  endtask

  task automatic test_rejects();
    logic [31:0] rd; logic e; int lat;
    preload(12'd0, 32'h11111111);
    preload(12'd4095, 32'h0BADF00D);
    we_cnt = 0;
    access(1'b1, 1'b1, 32'h2, 32'hBADBAD00, rd, e, lat);
    n_vec++;
    if (lat !== 2 || e !== 1'b1 || rd !== 32'd0) begin
      n_err++; $display("FAIL rej_misaligned: lat=%0d err=%b rdata=%h want 2 1 0", lat, e, rd);
    end
    access(1'b1, 1'b1, 32'h4000, 32'hBADBAD00, rd, e, lat);
    n_vec++;
    if (lat !== 2 || e !== 1'b1 || rd !== 32'd0) begin
      n_err++; $display("FAIL rej_range: lat=%0d err=%b rdata=%h want 2 1 0", lat, e, rd);
    end
    n_vec++;
    if (we_cnt !== 0 || mem[0] !== 32'h11111111) begin
      n_err++; $display("FAIL rej_no_write: we_cycles=%0d mem0=%h want 0 11111111", we_cnt, mem[0]);
    end
    access(1'b0, 1'b0, 32'h15, 32'd0, rd, e, lat);
    n_vec++;
    if (e !== 1'b1 || rd !== 32'd0) begin
      n_err++; $display("FAIL rej_fetch: err=%b rdata=%h want 1 0", e, rd);
    end
    access(1'b1, 1'b0, 32'h3FFC, 32'd0, rd, e, lat);
    n_vec++;
    if (e !== 1'b0 || rd !== 32'h0BADF00D) begin
      n_err++; $display("FAIL top_word: err=%b rdata=%h want 0 0badf00d", e, rd);
    end
  endtask

  task automatic test_contention();
    int ci, cd; logic [31:0] ir, dr; logic [31:0] rd; logic e; int lat;
    apply_reset();
    both_round(ci, cd, ir, dr);
    n_vec++;
    if (ci !== 2 || cd !== 4) begin
      n_err++; $display("FAIL contend_order1: i_ack@%0d d_ack@%0d want 2 4", ci, cd);
    end
    n_vec++;
    if (ir !== 32'hDEADBEEF || dr !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL contend_data: i=%h d=%h want deadbeef cafef00d", ir, dr);
    end
    // Completing d handed priority back to i; a lone fetch passes it to d.
    access(1'b0, 1'b0, 32'h14, 32'd0, rd, e, lat);
    both_round(ci, cd, ir, dr);
    n_vec++;
    if (cd !== 2 || ci !== 4) begin
      n_err++; $display("FAIL contend_order2: d_ack@%0d i_ack@%0d want 2 4", cd, ci);
    end
  endtask

  task automatic test_back_to_back();
    int n; int ack_cyc[8]; bit ack_id[8];
    n = 0;
    for (int k = 0; k < 8; k++) begin ack_cyc[k] = -1; ack_id[k] = 1'b0; end
    // Priority sits with d after the last contention round ended on an i access.
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h14;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    for (int c = 1; c <= 40 && n < 8; c++) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) begin
        ack_id[n] = bus.d_ack; ack_cyc[n] = c; n++;
        if (n == 8) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
      end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    n_vec++;
    if (n !== 8) begin n_err++; $display("FAIL alt_count: got %0d acks want 8", n); end
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (ack_id[k] !== ((k % 2) == 0) || ack_cyc[k] !== 2 + 2 * k) begin
        n_err++; $display("FAIL alt_ack%0d: d=%b cycle=%0d want d=%b cycle=%0d",
                          k, ack_id[k], ack_cyc[k], (k % 2) == 0, 2 + 2 * k);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_store();
    preload(12'd8, 32'hAAAA5555);
    ack_cnt = 0;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h12345678;
    @(negedge clk);
    n_vec++;
    if (bus.ram_we !== 1'b1 || bus.ram_a !== 32'd8) begin
      n_err++; $display("FAIL mid_issue: ram_we=%b ram_a=%h want 1 8", bus.ram_we, bus.ram_a);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({bus.ram_we, bus.i_ack, bus.d_ack, bus.err, bus.busy} !== 5'b0) begin
      n_err++; $display("FAIL mid_reset_ctrl: got %b want 00000",
                        {bus.ram_we, bus.i_ack, bus.d_ack, bus.err, bus.busy});
    end
    n_vec++;
    if ({bus.ram_a, bus.ram_wd, bus.i_rdata, bus.d_rdata} !== 128'd0) begin
      n_err++; $display("FAIL mid_reset_data: ram_a=%h ram_wd=%h i_rdata=%h d_rdata=%h want all 0",
                        bus.ram_a, bus.ram_wd, bus.i_rdata, bus.d_rdata);
    end
    @(negedge clk);
    bus.d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (ack_cnt !== 0 || mem[8] !== 32'hAAAA5555 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL mid_abort: acks=%0d mem8=%h busy=%b want 0 aaaa5555 0",
                        ack_cnt, mem[8], bus.busy);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; we_cnt = 0; ack_cnt = 0;
    we_a = 32'd0; we_wd = 32'd0;
    pre_we = 1'b0; pre_a = 12'd0; pre_d = 32'd0;
    test_reset();
    test_single_load();
    test_store_fetch();
    test_rejects();
    test_contention();
    test_back_to_back();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
